// File: rtl/iop_mem_responder_if.sv
// IOP request/ack channel plus memory port of the IOP memory responder.
// The responder takes the slave modport; the initiator/memory side takes the master modport.
interface iop_mem_responder_if;
  localparam int unsigned ADDR_W = 22;
  localparam int unsigned DATA_W = 64;

  logic [ADDR_W-1:0] iop_addr;
  logic [DATA_W-1:0] iop_data;
  logic              iop_req;
  logic              iop_wr;
  logic              iop_ack;
  logic [DATA_W-1:0] iop_rd_data;
  logic              iop_err;

  logic              mem_busy;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  iop_addr, iop_data, iop_req, iop_wr, mem_busy, mem_rdata,
    output iop_ack, iop_rd_data, iop_err, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output iop_addr, iop_data, iop_req, iop_wr, mem_busy, mem_rdata,
    input  iop_ack, iop_rd_data, iop_err, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/iop_mem_responder.sv
// Serves one IOP word request at a time against memory shared with the CPU,
// yielding to the CPU while it holds the memory and flagging out-of-range addresses.
module iop_mem_responder #(
  parameter int unsigned RD_LAT   = 2,
  parameter logic [21:0] MAX_ADDR = 22'h0FFFFF
) (
  input  logic                  clk,
  input  logic                  rst,
  iop_mem_responder_if.slave    bus,
  output logic [15:0]           wr_count,
  output logic [7:0]            err_count
);
  localparam int unsigned ADDR_W = 22;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RWAIT = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t            state;
  logic              req_wr;
  logic [CNT_W-1:0]  lat_cnt;
  logic              ack;
  logic              err;
  logic [DATA_W-1:0] rd_data;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  // Single-cycle strobes and read data default low, so they are only seen in ISSUE/ACK.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_wr    <= 1'b0;
      lat_cnt   <= '0;
      ack       <= 1'b0;
      err       <= 1'b0;
      rd_data   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wr_count  <= '0;
      err_count <= '0;
    end else begin
      ack     <= 1'b0;
      err     <= 1'b0;
      rd_data <= '0;
      mem_en  <= 1'b0;
      mem_we  <= 1'b0;

      unique case (state)
        IDLE: begin
          if (bus.iop_req && !bus.mem_busy) begin
            req_wr    <= bus.iop_wr;
            mem_addr  <= bus.iop_addr;
            mem_wdata <= bus.iop_data;
            if (bus.iop_addr > MAX_ADDR) begin
              state <= ACK;
              ack   <= 1'b1;
              err   <= 1'b1;
              if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end else begin
              state  <= ISSUE;
              mem_en <= 1'b1;
              mem_we <= bus.iop_wr;
            end
          end
        end

        ISSUE: begin
          if (req_wr) begin
            state <= ACK;
            ack   <= 1'b1;
            if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
          end else begin
            state   <= RWAIT;
            lat_cnt <= CNT_W'(RD_LAT - 1);
          end
        end

        // Read data lands RD_LAT cycles after the enable cycle; capture it on the final RWAIT edge.
        RWAIT: begin
          if (lat_cnt == '0) begin
            state   <= ACK;
            ack     <= 1'b1;
            rd_data <= bus.mem_rdata;
          end else begin
            lat_cnt <= lat_cnt - CNT_W'(1);
          end
        end

        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.iop_ack     = ack;
  assign bus.iop_err     = err;
  assign bus.iop_rd_data = rd_data;
  assign bus.mem_en      = mem_en;
  assign bus.mem_we      = mem_we;
  assign bus.mem_addr    = mem_addr;
  assign bus.mem_wdata   = mem_wdata;
endmodule

// File: tb/tb_iop_mem_responder.sv
// Directed, table-driven bench for iop_mem_responder with a fixed-latency memory model.
module tb_iop_mem_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] wr_count;
  logic [7:0]  err_count;
  int          checks = 0;
  int          errors = 0;

  iop_mem_responder_if bus();

  iop_mem_responder #(.RD_LAT(2), .MAX_ADDR(22'h0FFFFF)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .wr_count  (wr_count),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  // Memory model: read data valid two cycles after the enable cycle, junk otherwise.
  logic        en_d1 = 1'b0, en_d2 = 1'b0;
  logic [21:0] a_d1 = '0, a_d2 = '0;

  function automatic logic [63:0] mem_model(input logic [21:0] a);
    return (a == 22'h8DC) ? 64'h7C9 : (64'hA5A5_0000_0000_0000 | 64'(a));
  endfunction

  always @(posedge clk) begin
    en_d1 <= bus.mem_en & ~bus.mem_we;
    a_d1  <= bus.mem_addr;
    en_d2 <= en_d1;
    a_d2  <= a_d1;
  end

  always_comb bus.mem_rdata = en_d2 ? mem_model(a_d2) : 64'hBAD0_BAD0_BAD0_BAD0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One request; latencies are counted in cycles, cycle 0 being the first cycle req is high.
  task automatic do_txn(input logic wr, input logic [21:0] addr, input logic [63:0] data,
                        input int busy_cyc, output int lat, output int en_cnt, output int en_cyc,
                        output logic en_we, output logic [21:0] en_addr,
                        output logic [63:0] en_wdata, output logic err, output logic [63:0] rd);
    lat = -1; en_cnt = 0; en_cyc = -1; en_we = 1'b0; en_addr = '0; en_wdata = '0;
    err = 1'b0; rd = '0;
    @(posedge clk); #1;
    bus.iop_addr = addr; bus.iop_data = data; bus.iop_wr = wr;
    bus.iop_req = 1'b1; bus.mem_busy = (busy_cyc > 0);
    for (int c = 0; c < 40 && lat < 0; c++) begin
      @(negedge clk);
      if (bus.mem_en) begin
        en_cnt++; en_cyc = c; en_we = bus.mem_we; en_addr = bus.mem_addr; en_wdata = bus.mem_wdata;
      end
      if (bus.iop_ack) begin
        lat = c; err = bus.iop_err; rd = bus.iop_rd_data;
      end
      @(posedge clk); #1;
      if (c + 1 >= busy_cyc) bus.mem_busy = 1'b0;
      if (c == busy_cyc) begin
        bus.iop_addr = ~addr; bus.iop_data = ~data; bus.iop_wr = ~wr;
      end
    end
    bus.iop_req = 1'b0;
  endtask

  // After an ack: no further ack, enable, error or read data for a few idle cycles.
  task automatic quiet(input string name);
    int bad = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.iop_ack || bus.mem_en || bus.iop_err || (bus.iop_rd_data != '0)) bad++;
    end
    chk(name, 64'(bad), 64'd0);
  endtask

  typedef struct {
    logic        wr;
    logic [21:0] addr;
    logic [63:0] data;
    int          busy;
    int          exp_lat;
    int          exp_en;
    logic [63:0] exp_rd;
    logic        exp_err;
    logic [15:0] exp_wc;
    logic [7:0]  exp_ec;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int lat, en_cnt, en_cyc, acks, en_tot, bad;
    logic en_we, err;
    logic [21:0] en_addr;
    logic [63:0] en_wdata, rd;

    vecs[0] = '{1'b1, 22'h207B,   64'h0C00_8207_A040_08C7, 0, 2, 1, 64'h0,                   1'b0, 16'd1, 8'd0};
    vecs[1] = '{1'b0, 22'h8DC,    64'h0,                   0, 4, 1, 64'h7C9,                 1'b0, 16'd1, 8'd0};
    vecs[2] = '{1'b1, 22'h3FF,    64'h1122_3344_5566_7788, 3, 5, 1, 64'h0,                   1'b0, 16'd2, 8'd0};
    vecs[3] = '{1'b1, 22'h100000, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 0, 64'h0,                   1'b1, 16'd2, 8'd1};
    vecs[4] = '{1'b0, 22'h0FFFFF, 64'h0,                   0, 4, 1, 64'hA5A5_0000_000F_FFFF, 1'b0, 16'd2, 8'd1};
    vecs[5] = '{1'b0, 22'h3FFFFF, 64'h0,                   1, 2, 0, 64'h0,                   1'b1, 16'd2, 8'd2};
    vecs[6] = '{1'b0, 22'h12345,  64'h0,                   2, 6, 1, 64'hA5A5_0000_0001_2345, 1'b0, 16'd2, 8'd2};
    vecs[7] = '{1'b1, 22'h0,      64'hDEAD_BEEF,           0, 2, 1, 64'h0,                   1'b0, 16'd3, 8'd2};

    bus.iop_addr = '0; bus.iop_data = '0; bus.iop_req = 1'b0; bus.iop_wr = 1'b0; bus.mem_busy = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset ack",      64'(bus.iop_ack), 64'd0);
    chk("reset err",      64'(bus.iop_err), 64'd0);
    chk("reset mem_en",   64'(bus.mem_en),  64'd0);
    chk("reset rd_data",  bus.iop_rd_data,  64'd0);
    chk("reset mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("reset wr_count", 64'(wr_count),    64'd0);
    chk("reset err_count",64'(err_count),   64'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      do_txn(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].busy,
             lat, en_cnt, en_cyc, en_we, en_addr, en_wdata, err, rd);
      chk($sformatf("v%0d ack latency", i), 64'(lat), 64'(vecs[i].exp_lat));
      chk($sformatf("v%0d mem_en count", i), 64'(en_cnt), 64'(vecs[i].exp_en));
      if (vecs[i].exp_en == 1) begin
        chk($sformatf("v%0d mem_en cycle", i), 64'(en_cyc), 64'(vecs[i].busy + 1));
        chk($sformatf("v%0d mem_we", i), 64'(en_we), 64'(vecs[i].wr));
        chk($sformatf("v%0d mem_addr", i), 64'(en_addr), 64'(vecs[i].addr));
        if (vecs[i].wr) chk($sformatf("v%0d mem_wdata", i), en_wdata, vecs[i].data);
      end
      chk($sformatf("v%0d err", i), 64'(err), 64'(vecs[i].exp_err));
      chk($sformatf("v%0d rd_data", i), rd, vecs[i].exp_rd);
      chk($sformatf("v%0d wr_count", i), 64'(wr_count), 64'(vecs[i].exp_wc));
      chk($sformatf("v%0d err_count", i), 64'(err_count), 64'(vecs[i].exp_ec));
      quiet($sformatf("v%0d post-ack idle", i));
    end

    // Reset while the read is waiting for memory: aborted, late data ignored.
    @(posedge clk); #1;
    bus.iop_addr = 22'h8DC; bus.iop_wr = 1'b0; bus.iop_req = 1'b1; bus.mem_busy = 1'b0;
    @(posedge clk); #1;
    bus.iop_req = 1'b0;
    @(negedge clk);
    chk("abort issue mem_en", 64'(bus.mem_en), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    acks = 0; bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.iop_ack) acks++;
      if (bus.iop_err || bus.mem_en || bus.mem_we || (bus.iop_rd_data != '0) ||
          (bus.mem_addr != '0) || (bus.mem_wdata != '0)) bad++;
    end
    chk("abort ack count", 64'(acks), 64'd0);
    chk("abort outputs zero", 64'(bad), 64'd0);
    chk("abort wr_count", 64'(wr_count), 64'd0);
    chk("abort err_count", 64'(err_count), 64'd0);

    do_txn(1'b0, 22'h8DC, 64'h0, 0, lat, en_cnt, en_cyc, en_we, en_addr, en_wdata, err, rd);
    chk("post-abort read latency", 64'(lat), 64'd4);
    chk("post-abort read data", rd, 64'h7C9);

    // Seven back-to-back writes with req dropped for one cycle between them.
    acks = 0; en_tot = 0;
    for (int i = 0; i < 7; i++) begin
      do_txn(1'b1, 22'(i * 16 + 5), 64'(i) * 64'h0101_0101, 0,
             lat, en_cnt, en_cyc, en_we, en_addr, en_wdata, err, rd);
      if (lat == 2) acks++;
      en_tot += en_cnt;
    end
    quiet("burst tail idle");
    chk("burst ack count", 64'(acks), 64'd7);
    chk("burst mem_en count", 64'(en_tot), 64'd7);
    chk("burst wr_count", 64'(wr_count), 64'd7);
    chk("burst err_count", 64'(err_count), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
